// File: rtl/accel_led_sequencer.sv
// rtl/accel_led_sequencer.sv - accelerometer sample sequencer feeding the LED bar driver
//
// Purpose:
//   On every sample tick, reads the X, Y and Z data registers through a
//   request/acknowledge register-read port. Each 10-bit two's-complement
//   sample is latched. The sequencer then shows either a fixed axis or an
//   auto-cycled axis on oDIG. It also flags activity when the shown axis
//   moved by more than ACT_THRESH since the previous frame.
//
// Ports:
//   iCLK        system clock
//   iRST        synchronous reset, active-high
//   iEN         sampling enable
//   iAXIS_MODE  0 = X, 1 = Y, 2 = Z, 3 = auto-cycle X->Y->Z
//   oREQ        read request, held together with oADDR until iACK
//   oADDR       register address of the current read
//   iACK        read complete; iRDATA is valid in the same cycle
//   iRDATA      read data; bits [9:0] hold the sample
//   oDIG        displayed sample
//   oDIG_VLD    1-cycle pulse when oDIG updates
//   oACT        1-cycle activity pulse, coincident with oDIG_VLD
//   oAXIS       axis currently shown on oDIG
//   oTIMEOUT    sticky: a read was abandoned for lack of iACK
//   oOVR        sticky: a tick arrived while a tick was already pending

module accel_led_sequencer #(
    parameter int          SAMPLE_DIV  = 500000,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          ACT_THRESH  = 64,
    parameter int          AUTO_FRAMES = 200,
    parameter logic [5:0]  ADDR_X      = 6'h32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [1:0]  iAXIS_MODE,
    output logic        oREQ,
    output logic [5:0]  oADDR,
    input  logic        iACK,
    input  logic [15:0] iRDATA,
    output logic [9:0]  oDIG,
    output logic        oDIG_VLD,
    output logic        oACT,
    output logic [1:0]  oAXIS,
    output logic        oTIMEOUT,
    output logic        oOVR
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
    localparam logic [10:0]       THRESH    = 11'(ACT_THRESH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_NEXT,
        ST_UPDATE
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               pending_q, pending_d;
    logic [1:0]         idx_q, idx_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
    logic               first_frame_q, first_frame_d;
    logic [9:0]         samp_new_q [0:2];
    logic [9:0]         samp_new_d [0:2];
    logic [9:0]         samp_prev_q [0:2];
    logic [9:0]         samp_prev_d [0:2];
    logic [9:0]         dig_q, dig_d;
    logic               dig_vld_q, dig_vld_d;
    logic               act_q, act_d;
    logic [1:0]         axis_q, axis_d;
    logic               timeout_q, timeout_d;
    logic               ovr_q, ovr_d;

    logic               tick;
    logic               pend_take;
    logic [1:0]         disp_axis;
    logic [AUTO_W-1:0]  auto_nxt;
    logic [9:0]         sel_new;
    logic [9:0]         sel_prev;
    logic signed [10:0] delta;
    logic [10:0]        delta_mag;

    // Upper read-data bits carry no sample information.
    logic unused_rdata;
    assign unused_rdata = ^iRDATA[15:10];

    // Request and address come straight from the state and axis index.
    // They are therefore stable for the whole handshake, and they drop on
    // the edge that leaves WAIT_ACK or applies reset.
    assign oREQ  = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);
    assign oADDR = oREQ ? (ADDR_X + {3'b000, idx_q, 1'b0}) : 6'd0;

    assign oDIG     = dig_q;
    assign oDIG_VLD = dig_vld_q;
    assign oACT     = act_q;
    assign oAXIS    = axis_q;
    assign oTIMEOUT = timeout_q;
    assign oOVR     = ovr_q;

    // Sample tick and the 1-deep pending flag. A tick landing in the same
    // cycle that IDLE consumes the pending flag simply re-arms it, so that
    // case is not an overrun.
    always_comb begin
        tick       = iEN && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (!iEN || tick) begin
            tick_cnt_d = '0;
        end
        pend_take = (state_q == ST_IDLE) && pending_q && iEN;
        pending_d = tick || (pending_q && !pend_take);
        ovr_d     = ovr_q || (tick && pending_q && !pend_take);
    end

    // Displayed-axis resolution, used only in UPDATE. In auto mode the
    // display advances from the axis currently shown. The counter is parked
    // at 0 in fixed modes, so switching to auto starts on the fixed axis.
    always_comb begin
        disp_axis = iAXIS_MODE;
        auto_nxt  = '0;
        if (iAXIS_MODE == 2'd3) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_nxt  = '0;
                disp_axis = (axis_q == 2'd2) ? 2'd0 : axis_q + 2'd1;
            end else begin
                auto_nxt  = auto_cnt_q + 1'b1;
                disp_axis = axis_q;
            end
        end
        sel_new   = samp_new_q[disp_axis];
        sel_prev  = samp_prev_q[disp_axis];
        delta     = $signed({sel_new[9], sel_new}) - $signed({sel_prev[9], sel_prev});
        delta_mag = delta[10] ? (~delta + 11'd1) : delta;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        to_cnt_d      = to_cnt_q;
        auto_cnt_d    = auto_cnt_q;
        first_frame_d = first_frame_q;
        samp_new_d    = samp_new_q;
        samp_prev_d   = samp_prev_q;
        dig_d         = dig_q;
        axis_d        = axis_q;
        dig_vld_d     = 1'b0;
        act_d         = 1'b0;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_take) begin
                    idx_d   = 2'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (iACK) begin
                    samp_new_d[idx_q] = iRDATA[9:0];
                    state_d           = ST_NEXT;
                end else if (to_cnt_q == TO_LAST) begin
                    // Abandon the read and keep the previous sample.
                    timeout_d = 1'b1;
                    state_d   = ST_NEXT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                // Disable is honoured only between handshakes. Samples
                // already captured in this frame stay in place.
                if (!iEN) begin
                    state_d = ST_IDLE;
                end else if (idx_q != 2'd2) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                dig_d         = sel_new;
                axis_d        = disp_axis;
                dig_vld_d     = 1'b1;
                act_d         = !first_frame_q && (delta_mag > THRESH);
                samp_prev_d   = samp_new_q;
                first_frame_d = 1'b0;
                auto_cnt_d    = auto_nxt;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            pending_q     <= 1'b0;
            idx_q         <= 2'd0;
            to_cnt_q      <= '0;
            auto_cnt_q    <= '0;
            first_frame_q <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                samp_new_q[i]  <= '0;
                samp_prev_q[i] <= '0;
            end
            dig_q         <= '0;
            dig_vld_q     <= 1'b0;
            act_q         <= 1'b0;
            axis_q        <= 2'd0;
            timeout_q     <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            pending_q     <= pending_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            auto_cnt_q    <= auto_cnt_d;
            first_frame_q <= first_frame_d;
            samp_new_q    <= samp_new_d;
            samp_prev_q   <= samp_prev_d;
            dig_q         <= dig_d;
            dig_vld_q     <= dig_vld_d;
            act_q         <= act_d;
            axis_q        <= axis_d;
            timeout_q     <= timeout_d;
            ovr_q         <= ovr_d;
        end
    end

endmodule

// File: tb/tb_accel_led_sequencer.sv
// tb/tb_accel_led_sequencer.sv - directed self-checking bench for accel_led_sequencer
module tb_accel_led_sequencer;

    localparam logic [5:0] ADDR_X = 6'h32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  axis_mode;
    logic        req;
    logic [5:0]  addr;
    logic        ack;
    logic [15:0] rdata;
    logic [9:0]  dig;
    logic        dig_vld;
    logic        act;
    logic [1:0]  axis;
    logic        tmo;
    logic        ovr;

    logic        en_2;
    logic [1:0]  axis_mode_2;
    logic        req_2;
    logic [5:0]  addr_2;
    logic        ack_2;
    logic [15:0] rdata_2;
    logic [9:0]  dig_2;
    logic        dig_vld_2;
    logic        act_2;
    logic [1:0]  axis_2;
    logic        tmo_2;
    logic        ovr_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accel_led_sequencer #(
        .SAMPLE_DIV (1000),
        .ACK_TIMEOUT(255),
        .ACT_THRESH (64),
        .AUTO_FRAMES(2),
        .ADDR_X     (ADDR_X)
    ) dut (
        .iCLK(clk), .iRST(rst), .iEN(en), .iAXIS_MODE(axis_mode),
        .oREQ(req), .oADDR(addr), .iACK(ack), .iRDATA(rdata),
        .oDIG(dig), .oDIG_VLD(dig_vld), .oACT(act), .oAXIS(axis),
        .oTIMEOUT(tmo), .oOVR(ovr)
    );

    accel_led_sequencer #(
        .SAMPLE_DIV (20),
        .ACK_TIMEOUT(255),
        .ACT_THRESH (64),
        .AUTO_FRAMES(200),
        .ADDR_X     (ADDR_X)
    ) dut_ovr (
        .iCLK(clk), .iRST(rst), .iEN(en_2), .iAXIS_MODE(axis_mode_2),
        .oREQ(req_2), .oADDR(addr_2), .iACK(ack_2), .iRDATA(rdata_2),
        .oDIG(dig_2), .oDIG_VLD(dig_vld_2), .oACT(act_2), .oAXIS(axis_2),
        .oTIMEOUT(tmo_2), .oOVR(ovr_2)
    );

    typedef struct {
        logic [1:0] mode;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] z;
        logic [9:0] e_dig;
        logic [1:0] e_axis;
        logic       e_act;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Drives one frame: acks each read 3 cycles after its request, or lets
    // the Y read time out when skip_y is set, then checks the update pulse.
    task automatic run_frame(input string tag, input logic [1:0] m,
                             input logic [9:0] x, input logic [9:0] y, input logic [9:0] z,
                             input bit skip_y, input logic [9:0] e_dig,
                             input logic [1:0] e_axis, input logic e_act);
        logic [9:0] d [3];
        int n;
        d[0] = x;
        d[1] = y;
        d[2] = z;
        axis_mode = m;
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (!req && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_req"}, req, 1);
            if (!req) return;
            chk({tag, "_addr"}, addr, ADDR_X + 6'(2 * a));
            if (a == 1 && skip_y) begin
                n = 1;
                while (req && n < 400) begin
                    @(negedge clk);
                    if (req) n++;
                end
                chk({tag, "_req_cycles"}, n, 256);
                chk({tag, "_timeout"}, tmo, 1);
            end else begin
                repeat (3) @(negedge clk);
                ack   = 1'b1;
                rdata = {6'h2A, d[a]};
                @(negedge clk);
                ack   = 1'b0;
                rdata = 16'h0;
            end
        end
        // Z ack was sampled on the edge before this point: NEXT now,
        // UPDATE after one more edge, pulse visible after the second.
        chk({tag, "_vld_early1"}, dig_vld, 0);
        @(negedge clk);
        chk({tag, "_vld_early2"}, dig_vld, 0);
        @(negedge clk);
        chk({tag, "_vld"}, dig_vld, 1);
        chk({tag, "_dig"}, dig, e_dig);
        chk({tag, "_axis"}, axis, e_axis);
        chk({tag, "_act"}, act, e_act);
        @(negedge clk);
        chk({tag, "_vld_pulse"}, dig_vld, 0);
        chk({tag, "_act_pulse"}, act, 0);
        chk({tag, "_dig_hold"}, dig, e_dig);
    endtask

    initial begin
        int  n;
        int  frames;
        int  c;
        bit  bad;

        rst = 1'b1; en = 1'b0; axis_mode = 2'd0; ack = 1'b0; rdata = 16'h0;
        en_2 = 1'b0; axis_mode_2 = 2'd0; ack_2 = 1'b0; rdata_2 = 16'h0;

        //           mode   X        Y        Z        dig      axis  act
        tv[0]  = '{2'd0, 10'h040, 10'h3C0, 10'h100, 10'h040, 2'd0, 1'b0};
        tv[1]  = '{2'd0, 10'h0C1, 10'h3C0, 10'h100, 10'h0C1, 2'd0, 1'b1};
        tv[2]  = '{2'd0, 10'h0C1, 10'h3C0, 10'h100, 10'h0C1, 2'd0, 1'b0};
        tv[3]  = '{2'd0, 10'h3E0, 10'h3C0, 10'h100, 10'h3E0, 2'd0, 1'b1};
        tv[4]  = '{2'd0, 10'h020, 10'h3C0, 10'h100, 10'h020, 2'd0, 1'b0};
        tv[5]  = '{2'd1, 10'h020, 10'h3C0, 10'h100, 10'h3C0, 2'd1, 1'b0};
        tv[6]  = '{2'd2, 10'h020, 10'h3C0, 10'h100, 10'h100, 2'd2, 1'b0};
        tv[7]  = '{2'd0, 10'h020, 10'h3C0, 10'h100, 10'h020, 2'd0, 1'b0};
        tv[8]  = '{2'd3, 10'h020, 10'h3C0, 10'h100, 10'h020, 2'd0, 1'b0};
        tv[9]  = '{2'd3, 10'h020, 10'h000, 10'h100, 10'h000, 2'd1, 1'b0};
        tv[10] = '{2'd3, 10'h020, 10'h3BF, 10'h100, 10'h3BF, 2'd1, 1'b1};
        tv[11] = '{2'd3, 10'h020, 10'h3BF, 10'h1F0, 10'h1F0, 2'd2, 1'b1};
        tv[12] = '{2'd3, 10'h020, 10'h3BF, 10'h1F0, 10'h1F0, 2'd2, 1'b0};
        tv[13] = '{2'd3, 10'h020, 10'h3BF, 10'h1F0, 10'h020, 2'd0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dig", dig, 0);
        chk("rst_vld", dig_vld, 0);
        chk("rst_act", act, 0);
        chk("rst_axis", axis, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_ovr", ovr, 0);

        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_frame($sformatf("row%0d", i), tv[i].mode, tv[i].x, tv[i].y, tv[i].z,
                      1'b0, tv[i].e_dig, tv[i].e_axis, tv[i].e_act);
        end

        // Disable during the Y handshake: Y is still captured, no Z read,
        // no display update.
        axis_mode = 2'd0;
        n = 0;
        while (!req && n < 3000) begin @(negedge clk); n++; end
        chk("abort_req_x", req, 1);
        chk("abort_addr_x", addr, 6'h32);
        repeat (3) @(negedge clk);
        ack = 1'b1; rdata = {6'h00, 10'h111};
        @(negedge clk);
        ack = 1'b0; rdata = 16'h0;
        n = 0;
        while (!req && n < 100) begin @(negedge clk); n++; end
        chk("abort_addr_y", addr, 6'h34);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        ack = 1'b1; rdata = {6'h00, 10'h155};
        @(negedge clk);
        ack = 1'b0; rdata = 16'h0;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (req || dig_vld) bad = 1'b1;
        end
        chk("abort_idle", bad, 0);
        chk("abort_dig_hold", dig, 10'h020);

        // Y read times out; the Y captured by the aborted frame is shown.
        en = 1'b1;
        run_frame("tmo", 2'd1, 10'h111, 10'h000, 10'h1F0, 1'b1, 10'h155, 2'd1, 1'b1);
        run_frame("post_tmo", 2'd1, 10'h111, 10'h155, 10'h1F0, 1'b0, 10'h155, 2'd1, 1'b0);
        chk("timeout_sticky", tmo, 1);
        chk("no_ovr", ovr, 0);

        // Reset in the middle of a handshake.
        axis_mode = 2'd0;
        n = 0;
        while (!req && n < 3000) begin @(negedge clk); n++; end
        chk("mid_req", req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_dig", dig, 0);
        chk("mid_rst_vld", dig_vld, 0);
        chk("mid_rst_act", act, 0);
        chk("mid_rst_axis", axis, 0);
        chk("mid_rst_timeout", tmo, 0);
        chk("mid_rst_ovr", ovr, 0);
        rst = 1'b0;
        run_frame("after_rst", 2'd0, 10'h0C1, 10'h000, 10'h000, 1'b0, 10'h0C1, 2'd0, 1'b0);

        // Short sample period with slow acks: overrun, frames keep flowing.
        en_2   = 1'b1;
        frames = 0;
        c      = 0;
        n      = 0;
        while (frames < 5 && n < 3000) begin
            @(negedge clk);
            n++;
            ack_2 = 1'b0;
            if (dig_vld_2) frames++;
            if (req_2) begin
                if (c == 14) begin
                    ack_2   = 1'b1;
                    rdata_2 = {10'h000, addr_2};
                    c = 0;
                end else begin
                    c++;
                end
            end else begin
                c = 0;
            end
        end
        ack_2 = 1'b0;
        chk("ovr_frames", frames, 5);
        chk("ovr_flag", ovr_2, 1);
        chk("ovr_dig", dig_2, 10'h032);
        chk("ovr_axis", axis_2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
